// File: rtl/hub75_bcm_driver_if.sv
// Frame-store read bus between the HUB75 scanner (master) and the
// double-buffered pixel RAM (slave). Data follows a read strobe by one cycle.
interface hub75_bcm_driver_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 24
);
  logic [ADDR_W-1:0] FB_ADDR;
  logic              FB_RD;
  logic [DATA_W-1:0] FB_DATA0;
  logic [DATA_W-1:0] FB_DATA1;

  modport master (output FB_ADDR, output FB_RD, input FB_DATA0, input FB_DATA1);
  modport slave  (input FB_ADDR, input FB_RD, output FB_DATA0, output FB_DATA1);
endinterface

// File: rtl/hub75_bcm_driver.sv
// HUB75 dual-bank panel scanner with binary-coded modulation.
// One bit-plane is shifted per row pass; the OE-on time of plane p is
// BASE_ON<<p. The displayed frame buffer flips only at frame boundaries.
module hub75_bcm_driver #(
  parameter int COLS         = 32,
  parameter int ROW_BITS     = 4,
  parameter int DEPTH        = 8,
  parameter int CLK_DIV      = 4,
  parameter int BLANK_CYCLES = 4,
  parameter int BASE_ON      = 32
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic                ENABLE,
  hub75_bcm_driver_if.master  fb,
  input  logic                SWAP_REQ,
  output logic                SWAP_ACK,
  output logic                FB_SEL,
  output logic                FRAME_DONE,
  output logic                R0,
  output logic                G0,
  output logic                B0,
  output logic                R1,
  output logic                G1,
  output logic                B1,
  output logic [ROW_BITS-1:0] ROW,
  output logic                CLK_O,
  output logic                LATCH,
  output logic                OE
);

  localparam int COL_W   = $clog2(COLS);
  localparam int PLANE_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAX_ON  = BASE_ON << (DEPTH - 1);
  localparam int MAX_SM  = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CNT_MAX = (MAX_ON > MAX_SM) ? MAX_ON : MAX_SM;
  // One shared phase counter serves shift half-periods, blanking, latch and display.
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_BLANK, S_LATCH, S_DISPLAY} state_t;

  state_t               state;
  logic [COL_W-1:0]     col;
  logic [ROW_BITS-1:0]  row;
  logic [PLANE_W-1:0]   plane;
  logic [CNT_W-1:0]     cnt;
  logic                 high;

  logic [DEPTH-1:0]     top_ch [3];
  logic [DEPTH-1:0]     bot_ch [3];
  logic [CNT_W-1:0]     on_last;
  logic                 last_plane;
  logic                 last_row;
  logic                 last_col;
  logic                 div_end;
  logic                 frame_end;
  logic                 next_sel;
  logic [ROW_BITS-1:0]  next_row;

  // Split each bank word into its R, G, B channels (index 0 = R).
  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    assign top_ch[gi] = fb.FB_DATA0[gi*DEPTH +: DEPTH];
    assign bot_ch[gi] = fb.FB_DATA1[gi*DEPTH +: DEPTH];
  end

  assign on_last    = CNT_W'((BASE_ON << plane) - 1);
  assign last_plane = (plane == PLANE_W'(DEPTH - 1));
  assign last_row   = (row == {ROW_BITS{1'b1}});
  assign last_col   = (col == COL_W'(COLS - 1));
  assign div_end    = (cnt == CNT_W'(CLK_DIV - 1));
  assign frame_end  = (state == S_DISPLAY) && (cnt == on_last) && last_plane && last_row;
  assign next_sel   = FB_SEL ^ (frame_end & SWAP_REQ);
  assign next_row   = last_plane ? (last_row ? '0 : row + 1'b1) : row;

  // Scan FSM: all panel and bus outputs are registered and set on state transitions.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state      <= S_IDLE;
      col        <= '0;
      row        <= '0;
      plane      <= '0;
      cnt        <= '0;
      high       <= 1'b0;
      fb.FB_ADDR <= '0;
      fb.FB_RD   <= 1'b0;
      SWAP_ACK   <= 1'b0;
      FB_SEL     <= 1'b0;
      FRAME_DONE <= 1'b0;
      R0 <= 1'b0; G0 <= 1'b0; B0 <= 1'b0;
      R1 <= 1'b0; G1 <= 1'b0; B1 <= 1'b0;
      ROW        <= '0;
      CLK_O      <= 1'b0;
      LATCH      <= 1'b0;
      OE         <= 1'b1;
    end else begin
      fb.FB_RD   <= 1'b0;
      FRAME_DONE <= 1'b0;
      SWAP_ACK   <= 1'b0;
      case (state)
        S_IDLE: begin
          OE <= 1'b1;
          if (ENABLE) begin
            state      <= S_SHIFT;
            row        <= '0;
            plane      <= '0;
            col        <= '0;
            cnt        <= '0;
            high       <= 1'b0;
            CLK_O      <= 1'b0;
            fb.FB_RD   <= 1'b1;
            fb.FB_ADDR <= {FB_SEL, {ROW_BITS{1'b0}}, {COL_W{1'b0}}};
          end
        end
        S_SHIFT: begin
          // Read data arrives on the second low cycle; hold it through the high phase.
          if (!high && cnt == CNT_W'(1)) begin
            R0 <= top_ch[0][plane]; G0 <= top_ch[1][plane]; B0 <= top_ch[2][plane];
            R1 <= bot_ch[0][plane]; G1 <= bot_ch[1][plane]; B1 <= bot_ch[2][plane];
          end
          if (!div_end) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (!high) begin
              high  <= 1'b1;
              CLK_O <= 1'b1;
            end else begin
              high  <= 1'b0;
              CLK_O <= 1'b0;
              if (last_col) begin
                state <= S_BLANK;
                ROW   <= row;
              end else begin
                col        <= col + 1'b1;
                fb.FB_RD   <= 1'b1;
                fb.FB_ADDR <= {FB_SEL, row, col + 1'b1};
              end
            end
          end
        end
        S_BLANK: begin
          if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
            cnt   <= '0;
            state <= S_LATCH;
            LATCH <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_LATCH: begin
          if (div_end) begin
            cnt   <= '0;
            LATCH <= 1'b0;
            OE    <= 1'b0;
            state <= S_DISPLAY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DISPLAY: begin
          if (cnt == on_last) begin
            cnt   <= '0;
            OE    <= 1'b1;
            plane <= last_plane ? '0 : plane + 1'b1;
            row   <= next_row;
            col   <= '0;
            high  <= 1'b0;
            if (frame_end) begin
              FRAME_DONE <= 1'b1;
              if (SWAP_REQ) begin
                FB_SEL   <= ~FB_SEL;
                SWAP_ACK <= 1'b1;
              end
            end
            if (frame_end && !ENABLE) begin
              state <= S_IDLE;
            end else begin
              state      <= S_SHIFT;
              fb.FB_RD   <= 1'b1;
              fb.FB_ADDR <= {next_sel, next_row, {COL_W{1'b0}}};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Scoreboard bench for hub75_bcm_driver: the stimulus process pushes the
// expected bus reads, shifted pixel bits, latched rows, OE-on lengths and
// frame-end events; a negedge monitor pops and compares as the DUT emits them.
module tb_hub75_bcm_driver;
  localparam int COLS = 4, ROW_BITS = 1, DEPTH = 2, CLK_DIV = 2, BLANK_CYCLES = 2, BASE_ON = 8;
  localparam int COL_W = $clog2(COLS);
  localparam int ROWS = 1 << ROW_BITS;
  localparam int ADDR_W = 1 + ROW_BITS + COL_W;
  localparam int PLANE_FIX = 2*CLK_DIV*COLS + BLANK_CYCLES + CLK_DIV;
  localparam int FRAME_CYC = ROWS * (DEPTH*PLANE_FIX + BASE_ON*((1 << DEPTH) - 1));
  localparam int NFRAMES = 4;

  logic clk = 0, rst, enable, swap_req;
  logic swap_ack, fb_sel, frame_done, r0, g0, b0, r1, g1, b1, clk_o, latch, oe;
  logic [ROW_BITS-1:0] row;
  int cyc = 0;

  hub75_bcm_driver_if #(.ADDR_W(ADDR_W), .DATA_W(3*DEPTH)) fb ();

  hub75_bcm_driver #(.COLS(COLS), .ROW_BITS(ROW_BITS), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV),
                     .BLANK_CYCLES(BLANK_CYCLES), .BASE_ON(BASE_ON)) dut (
    .CLK_I(clk), .RST_I(rst), .ENABLE(enable), .fb(fb), .SWAP_REQ(swap_req),
    .SWAP_ACK(swap_ack), .FB_SEL(fb_sel), .FRAME_DONE(frame_done),
    .R0(r0), .G0(g0), .B0(b0), .R1(r1), .G1(g1), .B1(b1),
    .ROW(row), .CLK_O(clk_o), .LATCH(latch), .OE(oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame-store model: both buffers in one array indexed by the full address.
  logic [3*DEPTH-1:0] mem_top [1 << ADDR_W];
  logic [3*DEPTH-1:0] mem_bot [1 << ADDR_W];
  always @(posedge clk) begin
    if (fb.FB_RD) begin
      fb.FB_DATA0 <= mem_top[fb.FB_ADDR];
      fb.FB_DATA1 <= mem_bot[fb.FB_ADDR];
    end
  end

  int vectors = 0, miscompares = 0;
  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [ADDR_W-1:0] q_addr [$];
  logic [5:0]        q_pix  [$];
  int                q_row  [$];
  int                q_on   [$];
  logic [1:0]        q_done [$];   // {last frame, swap expected}

  function automatic logic [5:0] exp_pix(input logic [ADDR_W-1:0] a, input int p);
    logic [3*DEPTH-1:0] d0, d1;
    d0 = mem_top[a];
    d1 = mem_bot[a];
    return {d0[p], d0[DEPTH+p], d0[2*DEPTH+p], d1[p], d1[DEPTH+p], d1[2*DEPTH+p]};
  endfunction

  // A frame scans every row; each row shows every plane; each plane shifts all columns.
  task automatic push_frame(input int sel);
    logic [ADDR_W-1:0] a;
    for (int r = 0; r < ROWS; r++)
      for (int p = 0; p < DEPTH; p++) begin
        for (int c = 0; c < COLS; c++) begin
          a = ADDR_W'((sel << (ROW_BITS + COL_W)) | (r << COL_W) | c);
          q_addr.push_back(a);
          q_pix.push_back(exp_pix(a, p));
        end
        q_row.push_back(r);
        q_on.push_back(BASE_ON << p);
      end
  endtask

  // Monitor
  bit mon_en = 0;
  initial begin
    logic prev_clko = 0, prev_latch = 0, prev_oe = 1;
    int clko_fall = 0, latch_start = 0, oe_start = 0, row_at_on = 0, ref_cyc = 0, npix = 0, nfr = 0;
    bit running = 0, mon_sel = 0;
    logic [5:0] got, expv;
    logic [1:0] d;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (fb.FB_RD) begin
          if (q_addr.size() == 0) check("unexpected_fb_rd", 1, 0);
          else check("fb_addr", int'(fb.FB_ADDR), int'(q_addr.pop_front()));
          if (!running) begin running = 1; ref_cyc = cyc; end
        end
        if (clk_o && !prev_clko) begin
          got = {r0, g0, b0, r1, g1, b1};
          if (q_pix.size() == 0) check("unexpected_clk_o", 1, 0);
          else begin
            expv = q_pix.pop_front();
            check("pixel_bits", int'(got), int'(expv));
            $display("pix %0d row %0d: bits %b expected %b", npix, row, got, expv);
            npix++;
          end
        end
        if (!clk_o && prev_clko) clko_fall = cyc;
        if (latch && !prev_latch) begin
          check("blank_len", cyc - clko_fall, BLANK_CYCLES);
          if (q_row.size() == 0) check("unexpected_latch", 1, 0);
          else check("latch_row", int'(row), q_row.pop_front());
          latch_start = cyc;
        end
        if (!latch && prev_latch) check("latch_len", cyc - latch_start, CLK_DIV);
        if (!oe && prev_oe) begin oe_start = cyc; row_at_on = int'(row); end
        if (oe && !prev_oe) begin
          if (q_on.size() == 0) check("unexpected_oe", 1, 0);
          else check("oe_on_len", cyc - oe_start, q_on.pop_front());
          check("row_stable_while_on", int'(row), row_at_on);
        end
        if (frame_done) begin
          if (q_done.size() == 0) check("unexpected_frame_done", 1, 0);
          else begin
            d = q_done.pop_front();
            check("frame_period", cyc - ref_cyc, FRAME_CYC);
            ref_cyc = cyc;
            check("swap_ack", int'(swap_ack), int'(d[0]));
            mon_sel ^= d[0];
            check("fb_sel", int'(fb_sel), int'(mon_sel));
            $display("frame %0d done at cycle %0d, swap %0d, fb_sel %0d", nfr, cyc, swap_ack, fb_sel);
            nfr++;
            if (d[1]) running = 0;
          end
        end else if (swap_ack) begin
          check("swap_ack_without_frame_done", 1, 0);
        end
      end
      prev_clko = clk_o; prev_latch = latch; prev_oe = oe;
    end
  end

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 2*FRAME_CYC && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1;
    end
    if (!seen) check("frame_done_timeout", 0, 1);
  endtask

  // Stimulus
  initial begin
    int sel = 0, swap, rd_seen;
    bit last, found;
    rst = 1; enable = 0; swap_req = 0;
    for (int a = 0; a < (1 << ADDR_W); a++) begin
      mem_top[a] = (3*DEPTH)'($urandom);
      mem_bot[a] = (3*DEPTH)'($urandom);
      // Buffer 0 red channel: value 1 in column 0 only, zero elsewhere.
      if (a < (1 << (ROW_BITS + COL_W)))
        mem_top[a][DEPTH-1:0] = (a % COLS == 0) ? DEPTH'(1) : DEPTH'(0);
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_oe", int'(oe), 1);
    check("rst_clk_o", int'(clk_o), 0);
    check("rst_latch", int'(latch), 0);
    check("rst_fb_rd", int'(fb.FB_RD), 0);
    check("rst_row", int'(row), 0);
    check("rst_fb_sel", int'(fb_sel), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_swap_ack", int'(swap_ack), 0);
    check("rst_r0", int'(r0), 0);
    @(negedge clk);
    rst = 0; mon_en = 1;
    repeat (5) @(negedge clk);
    check("idle_oe_before_enable", int'(oe), 1);

    push_frame(0);
    enable = 1;
    for (int k = 0; k < NFRAMES; k++) begin
      last = (k == NFRAMES - 1);
      repeat (28) @(negedge clk);
      if (last) enable = 0;
      repeat (12) @(negedge clk);
      swap = (k == 0) ? 1 : (last ? int'(sel == 0) : int'($urandom_range(0, 1)));
      swap_req = swap[0];
      q_done.push_back({last, swap[0]});
      sel ^= swap;
      if (!last) push_frame(sel);
      wait_done();
      swap_req = 0;
    end

    rd_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (fb.FB_RD) rd_seen++;
    end
    check("idle_no_fb_rd", rd_seen, 0);
    check("idle_oe", int'(oe), 1);
    check("scoreboard_drained",
          q_addr.size() + q_pix.size() + q_row.size() + q_on.size() + q_done.size(), 0);

    // Reset in the middle of a DISPLAY phase of row 1.
    mon_en = 0;
    enable = 1;
    found = 0;
    for (int i = 0; i < 2*FRAME_CYC && !found; i++) begin
      @(negedge clk);
      if (!oe && row == 1) found = 1;
    end
    check("reach_display_row1", int'(found), 1);
    check("sel_before_rst", int'(fb_sel), sel);
    rst = 1;
    @(posedge clk);
    #1;
    check("midrst_oe", int'(oe), 1);
    check("midrst_row", int'(row), 0);
    check("midrst_fb_sel", int'(fb_sel), 0);
    check("midrst_clk_o", int'(clk_o), 0);
    check("midrst_latch", int'(latch), 0);
    @(negedge clk);
    rst = 0; enable = 0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
